alu_sequencer: RTL

- Fetch/decode/control stage that sits directly upstream of the 2-bit ALU and drives it.
- Fetches 11-bit instructions from an external combinational program ROM and decodes opcode and register fields.
- Reads operands from an internal 4 x 2-bit register file, presents them with the opcode to the ALU, then writes the ALU result and status bit back.
- Single-issue; each instruction runs through a fixed multi-cycle sequence.

---
 rtl/alu_sequencer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// Fetch/decode/control sequencer for a 2-bit ALU: fetches 11-bit instructions
// from an external ROM, reads a 4x2-bit register file, drives the ALU and writes back.
module alu_sequencer #(
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] instr_addr,
  input  logic [10:0]       instr_data,
  output logic [4:0]        alu_op,
  output logic [1:0]        alu_a,
  output logic [1:0]        alu_b,
  input  logic [1:0]        alu_res,
  input  logic              alu_status,
  output logic              busy,
  output logic              done,
  output logic              flag,
  output logic [CNT_W-1:0]  retired,
  input  logic [1:0]        dbg_sel,
  output logic [1:0]        dbg_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT
  } state_t;

  localparam logic [4:0] OP_ALU_MAX = 5'd13;
  localparam logic [4:0] OP_LI      = 5'b11110;
  localparam logic [4:0] OP_HALT    = 5'b11111;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [10:0]         ir_q, ir_d;
  logic [4:0]          alu_op_q, alu_op_d;
  logic [1:0]          alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [1:0]          res_q, res_d;
  logic                stat_q, stat_d;
  logic [3:0][1:0]     regs_q, regs_d;
  logic                flag_q, flag_d;
  logic [CNT_W-1:0]    retired_q, retired_d;

  logic [4:0] opc;
  logic [1:0] dst, src_a, src_b;
  assign opc   = ir_q[10:6];
  assign dst   = ir_q[5:4];
  assign src_a = ir_q[3:2];
  assign src_b = ir_q[1:0];

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    alu_op_d  = alu_op_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    res_d     = res_q;
    stat_d    = stat_q;
    regs_d    = regs_q;
    flag_d    = flag_q;
    retired_d = retired_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = '0;
        end
      end
      S_FETCH: begin
        ir_d    = instr_data;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        // HALT leaves pc pointing at itself and does not retire
        if (opc == OP_HALT) begin
          state_d = S_HALT;
        end else begin
          alu_op_d = opc;
          alu_a_d  = regs_q[src_a];
          alu_b_d  = regs_q[src_b];
          state_d  = S_EXEC;
        end
      end
      S_EXEC: begin
        res_d   = alu_res;
        stat_d  = alu_status;
        state_d = S_WB;
      end
      S_WB: begin
        if (opc <= OP_ALU_MAX) begin
          regs_d[dst] = res_q;
          flag_d      = stat_q;
        end else if (opc == OP_LI) begin
          regs_d[dst] = src_a;
        end
        pc_d      = pc_q + ADDR_W'(1);
        retired_d = retired_q + CNT_W'(1);
        state_d   = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      alu_op_q  <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      res_q     <= '0;
      stat_q    <= 1'b0;
      regs_q    <= '0;
      flag_q    <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      alu_op_q  <= alu_op_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      res_q     <= res_d;
      stat_q    <= stat_d;
      regs_q    <= regs_d;
      flag_q    <= flag_d;
      retired_q <= retired_d;
    end
  end

  assign instr_addr = pc_q;
  assign alu_op     = alu_op_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign busy       = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                      (state_q == S_EXEC)  || (state_q == S_WB);
  assign done       = (state_q == S_HALT);
  assign flag       = flag_q;
  assign retired    = retired_q;
  assign dbg_data   = regs_q[dbg_sel];

endmodule
